dekatron_pulse_decoder: RTL

Receive-side counterpart to the dekatron guide-pulse sender. It samples the two-phase guide-pulse pair, rebuilds each completed step as +1 or −1, and keeps a modulo-COUNT position register that mirrors the glow position of the driven tube. It sits on the same clock as the sender, either in a dekatron model for simulation or as a shadow counter that checks a real tube. It also flags malformed pulse sequences, wrap-around carries and borrows.

---
 rtl/dekatron_pulse_decoder_if.sv | 19 +
 rtl/dekatron_pulse_decoder.sv | 88 ++++++++
 2 files changed

// File: rtl/dekatron_pulse_decoder_if.sv
// dekatron_pulse_decoder_if: guide-pulse inputs and decoded position outputs
interface dekatron_pulse_decoder_if #(parameter int VALUE_W = 4);
  logic en;
  logic [1:0] pulses;
  logic set;
  logic [VALUE_W-1:0] set_value;
  logic [VALUE_W-1:0] value;
  logic step;
  logic step_dir;
  logic carry;
  logic borrow;
  logic error;
  logic fault;
  logic busy;
  modport master (output en, pulses, set, set_value,
                  input value, step, step_dir, carry, borrow, error, fault, busy);
  modport slave (input en, pulses, set, set_value,
                 output value, step, step_dir, carry, borrow, error, fault, busy);
endinterface

// File: rtl/dekatron_pulse_decoder.sv
// dekatron_pulse_decoder: rebuilds +1/-1 steps from guide pulses into a modulo-COUNT position
module dekatron_pulse_decoder #(
  parameter int COUNT = 10,
  parameter int VALUE_W = 4
) (
  input logic clk,
  input logic rst,
  dekatron_pulse_decoder_if.slave bus
);
  typedef enum logic [2:0] {IDLE, INC_A, INC_B, DEC_A, DEC_B} state_t;
  localparam logic [VALUE_W-1:0] MAX = VALUE_W'(COUNT - 1);
  localparam logic [VALUE_W:0] CNT = (VALUE_W + 1)'(COUNT);
  state_t state, state_n;
  logic inc, dec, err, bad_set;
  logic [1:0] p;
  assign p = bus.pulses;
  assign bad_set = {1'b0, bus.set_value} >= CNT;
  assign bus.busy = state != IDLE;
  always_comb begin
    state_n = state;
    inc = 1'b0;
    dec = 1'b0;
    err = 1'b0;
    case (state)
      IDLE: begin
        state_n = p == 2'b01 ? INC_A : p == 2'b10 ? DEC_A : IDLE;
        err = p == 2'b11;
      end
      INC_A: begin
        state_n = p == 2'b01 ? INC_A : p == 2'b10 ? INC_B : IDLE;
        err = p == 2'b00 || p == 2'b11;
      end
      INC_B: begin
        state_n = p == 2'b10 ? INC_B : IDLE;
        inc = p == 2'b00;
        err = p == 2'b01 || p == 2'b11;
      end
      DEC_A: begin
        state_n = p == 2'b10 ? DEC_A : p == 2'b01 ? DEC_B : IDLE;
        err = p == 2'b00 || p == 2'b11;
      end
      DEC_B: begin
        state_n = p == 2'b01 ? DEC_B : IDLE;
        dec = p == 2'b00;
        err = p == 2'b10 || p == 2'b11;
      end
      default: begin
        state_n = IDLE;
        err = 1'b1;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      bus.value <= '0;
      bus.step <= 1'b0;
      bus.step_dir <= 1'b0;
      bus.carry <= 1'b0;
      bus.borrow <= 1'b0;
      bus.error <= 1'b0;
      bus.fault <= 1'b0;
    end else begin
      bus.step <= 1'b0;
      bus.carry <= 1'b0;
      bus.borrow <= 1'b0;
      bus.error <= 1'b0;
      if (bus.set) begin
        state <= IDLE;
        bus.value <= bad_set ? '0 : bus.set_value;
        bus.error <= bad_set;
        bus.fault <= bad_set;
      end else if (!bus.en) begin
        state <= IDLE;
      end else begin
        state <= state_n;
        bus.step <= inc || dec;
        bus.carry <= inc && bus.value == MAX;
        bus.borrow <= dec && bus.value == '0;
        bus.error <= err;
        bus.fault <= bus.fault || err;
        if (inc || dec) bus.step_dir <= dec;
        if (inc) bus.value <= bus.value == MAX ? '0 : bus.value + 1'b1;
        if (dec) bus.value <= bus.value == '0 ? MAX : bus.value - 1'b1;
      end
    end
  end
endmodule
